front_panel_jam: RTL and testbench

- Parametrised front-panel instruction jammer for the 8080 core.
- Accepts panel commands: RESET, EXAMINE and EXAMINE NEXT.
- For each command it takes over the CPU data-in path (jam_active). It feeds a short instruction sequence on successive rising edges of the CPU read strobe, then hands the bus back to memory.
- Sits between the panel switch debouncers and the CPU data-in mux. Replaces the fixed JMP-0000 jammer with a programmable-target, multi-op block.

---
 rtl/front_panel_jam_pkg.sv | 19 +
 rtl/front_panel_jam_rd_edge_sync.sv | 39 +++
 rtl/front_panel_jam.sv | 133 +++++++++++++
 tb/tb_front_panel_jam.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/front_panel_jam_pkg.sv
// Shared encodings for the front-panel instruction jammer: panel op codes,
// FSM state constants and the default 8080 opcodes it feeds to the CPU.
package front_panel_jam_pkg;

  localparam logic [1:0] OP_RESET   = 2'b00;
  localparam logic [1:0] OP_EXAMINE = 2'b01;
  localparam logic [1:0] OP_EXNEXT  = 2'b10;
  localparam logic [1:0] OP_RSVD    = 2'b11;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SKIP = 3'd1;
  localparam logic [2:0] ST_OPC  = 3'd2;
  localparam logic [2:0] ST_OPND = 3'd3;
  localparam logic [2:0] ST_REL  = 3'd4;

  localparam logic [7:0] OPC_JMP_8080 = 8'hC3;
  localparam logic [7:0] OPC_NOP_8080 = 8'h00;

endpackage

// File: rtl/front_panel_jam_rd_edge_sync.sv
// Optional synchroniser on the CPU read strobe followed by a rising-edge
// detector; rd_rise is high for exactly one clk per rd assertion.
module front_panel_jam_rd_edge_sync #(
  parameter int SYNC_STAGES = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic rd,
  output logic rd_rise
);

  logic rd_s;
  logic prev_rd;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign rd_s = rd;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      // NOTE: sequential state is always updated with non-blocking assignments
      // so every flop samples the pre-edge value of its neighbours.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= SYNC_STAGES'({sync_q, rd});
      end

      assign rd_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev_rd <= 1'b0;
    else          prev_rd <= rd_s;
  end

  assign rd_rise = rd_s & ~prev_rd;

endmodule

// File: rtl/front_panel_jam.sv
// Front-panel jammer: on a panel command it owns the CPU data-in path and
// feeds opcode + operand bytes on successive rd rising edges, then releases.
module front_panel_jam
  import front_panel_jam_pkg::*;
#(
  parameter int                 DATA_W      = 8,
  parameter int                 ADDR_W      = 16,
  parameter logic [DATA_W-1:0]  JMP_OPCODE  = DATA_W'(OPC_JMP_8080),
  parameter logic [DATA_W-1:0]  NOP_OPCODE  = DATA_W'(OPC_NOP_8080),
  parameter logic [ADDR_W-1:0]  RST_VECTOR  = '0,
  parameter int                 SKIP_RD     = 1,
  parameter int                 SYNC_STAGES = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic              cmd_ready,
  output logic              cmd_err,
  output logic [DATA_W-1:0] data_out,
  output logic              jam_active,
  output logic              done
);

  localparam int NB    = ADDR_W / DATA_W;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [2:0] FIRST_ST = (SKIP_RD > 0) ? ST_SKIP : ST_OPC;

  logic [2:0]        state;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] target;
  logic [1:0]        skip_cnt;
  logic [IDX_W-1:0]  idx;
  logic              rd_rise;
  logic              preempt;

  front_panel_jam_rd_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rd_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .rd      (rd),
    .rd_rise (rd_rise)
  );

  // A RESET command restarts any running sequence and swallows a coincident edge.
  assign preempt   = (state != ST_IDLE) && cmd_valid && (cmd_op == OP_RESET);
  assign cmd_ready = (state == ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      op_q       <= OP_RESET;
      target     <= '0;
      skip_cnt   <= '0;
      idx        <= '0;
      data_out   <= '0;
      jam_active <= 1'b0;
      done       <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      done    <= 1'b0;
      cmd_err <= 1'b0;

      if (preempt) begin
        op_q       <= OP_RESET;
        target     <= RST_VECTOR;
        skip_cnt   <= 2'(SKIP_RD);
        idx        <= '0;
        jam_active <= 1'b1;
        state      <= FIRST_ST;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cmd_valid) begin
              if (cmd_op == OP_RSVD) begin
                cmd_err <= 1'b1;
              end else begin
                op_q       <= cmd_op;
                target     <= (cmd_op == OP_RESET) ? RST_VECTOR : cmd_addr;
                skip_cnt   <= 2'(SKIP_RD);
                idx        <= '0;
                jam_active <= 1'b1;
                state      <= FIRST_ST;
              end
            end
          end

          ST_SKIP: begin
            if (rd_rise) begin
              skip_cnt <= skip_cnt - 2'd1;
              if (skip_cnt == 2'd1) state <= ST_OPC;
            end
          end

          ST_OPC: begin
            if (rd_rise) begin
              idx <= '0;
              if (op_q == OP_EXNEXT) begin
                data_out <= NOP_OPCODE;
                state    <= ST_REL;
              end else begin
                data_out <= JMP_OPCODE;
                state    <= ST_OPND;
              end
            end
          end

          ST_OPND: begin
            if (rd_rise) begin
              data_out <= target[idx*DATA_W +: DATA_W];
              if (idx == IDX_W'(NB - 1)) state <= ST_REL;
              else                      idx   <= idx + 1'b1;
            end
          end

          ST_REL: begin
            if (rd_rise) begin
              jam_active <= 1'b0;
              done       <= 1'b1;
              state      <= ST_IDLE;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_front_panel_jam.sv
// Bench for front_panel_jam: a queue-based sequence model checked every cycle,
// directed panel scenarios with literal byte checks, and a synchronised variant.
module tb_front_panel_jam;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rd, cmd_valid;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic        cmd_ready, cmd_err, jam_active, done;
  logic [7:0]  data_out;

  logic        rd2, cmd_valid2;
  logic        cmd_ready2, cmd_err2, jam_active2, done2;
  logic [7:0]  data_out2;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  bit seen_abcd = 1'b0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  front_panel_jam dut (
    .clk(clk), .reset_n(reset_n), .rd(rd), .cmd_valid(cmd_valid),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_ready(cmd_ready),
    .cmd_err(cmd_err), .data_out(data_out), .jam_active(jam_active),
    .done(done)
  );

  front_panel_jam #(.SYNC_STAGES(2), .SKIP_RD(0)) dut_sync (
    .clk(clk), .reset_n(reset_n), .rd(rd2), .cmd_valid(cmd_valid2),
    .cmd_op(2'b00), .cmd_addr(16'h0000), .cmd_ready(cmd_ready2),
    .cmd_err(cmd_err2), .data_out(data_out2), .jam_active(jam_active2),
    .done(done2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a command expands into a list of steps consumed one per rd rise.
  // Step -1 = ignored dummy fetch, -2 = release, otherwise a byte to drive.
  int         seq[$];
  bit         m_idle, m_jam, m_done, m_err, m_prev_rd, m_rise;
  logic [7:0] m_data;
  int         step;

  task automatic model_load(input logic [1:0] op, input logic [15:0] addr);
    logic [15:0] tgt;
    tgt = (op == 2'b00) ? 16'h0000 : addr;
    seq.delete();
    seq.push_back(-1);
    if (op == 2'b10) begin
      seq.push_back(8'h00);
    end else begin
      seq.push_back(8'hC3);
      seq.push_back(int'(tgt % 256));
      seq.push_back(int'(tgt / 256));
    end
    seq.push_back(-2);
    m_jam  = 1'b1;
    m_idle = 1'b0;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seq.delete();
      m_idle = 1'b1; m_jam = 1'b0; m_done = 1'b0; m_err = 1'b0;
      m_prev_rd = 1'b0; m_data = 8'h00;
    end else begin
      m_rise    = rd && !m_prev_rd;
      m_prev_rd = rd;
      m_done    = 1'b0;
      m_err     = 1'b0;
      if (!m_idle && cmd_valid && cmd_op == 2'b00) begin
        model_load(2'b00, 16'h0000);
      end else if (m_idle) begin
        if (cmd_valid) begin
          if (cmd_op == 2'b11) m_err = 1'b1;
          else                 model_load(cmd_op, cmd_addr);
        end
      end else if (m_rise && seq.size() > 0) begin
        step = seq.pop_front();
        if (step == -2) begin
          m_jam = 1'b0; m_done = 1'b1; m_idle = 1'b1;
        end else if (step >= 0) begin
          m_data = 8'(step);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc data_out",   32'(data_out),   32'(m_data));
      check("cyc jam_active", 32'(jam_active), 32'(m_jam));
      check("cyc done",       32'(done),       32'(m_done));
      check("cyc cmd_err",    32'(cmd_err),    32'(m_err));
      check("cyc cmd_ready",  32'(cmd_ready),  32'(m_idle));
      if (done)    done_cnt++;
      if (cmd_err) err_cnt++;
      if (data_out == 8'hAB || data_out == 8'hCD) seen_abcd = 1'b1;
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [15:0] addr);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_rd();
    @(negedge clk); rd = 1'b1;
    @(negedge clk);
    @(negedge clk); rd = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0, e0;
    reset_n = 1'b0; rd = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 16'h0;
    rd2 = 1'b0; cmd_valid2 = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    @(negedge clk);
    check("rst cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst jam_active", 32'(jam_active), 32'd0);
    check("rst data_out", 32'(data_out), 32'h00);

    // RESET: dummy, C3, 00, 00, release
    d0 = done_cnt;
    send_cmd(2'b00, 16'hFFFF);
    check("t1 jam after accept", 32'(jam_active), 32'd1);
    pulse_rd(); check("t1 dummy", 32'(data_out), 32'h00);
    check("t1 jam dummy", 32'(jam_active), 32'd1);
    pulse_rd(); check("t1 opc", 32'(data_out), 32'hC3);
    pulse_rd(); check("t1 lo", 32'(data_out), 32'h00);
    pulse_rd(); check("t1 hi", 32'(data_out), 32'h00);
    check("t1 jam before rel", 32'(jam_active), 32'd1);
    pulse_rd(); check("t1 jam rel", 32'(jam_active), 32'd0);
    check("t1 done count", 32'(done_cnt - d0), 32'd1);

    // EXAMINE 1234: dummy, C3, 34, 12, release
    send_cmd(2'b01, 16'h1234);
    pulse_rd(); check("t2 dummy", 32'(data_out), 32'h00);
    pulse_rd(); check("t2 opc", 32'(data_out), 32'hC3);
    pulse_rd(); check("t2 lo", 32'(data_out), 32'h34);
    pulse_rd(); check("t2 hi", 32'(data_out), 32'h12);
    check("t2 jam before rel", 32'(jam_active), 32'd1);
    pulse_rd(); check("t2 jam rel", 32'(jam_active), 32'd0);
    check("t2 data hold", 32'(data_out), 32'h12);

    // EXAMINE NEXT: dummy, 00, release
    d0 = done_cnt;
    send_cmd(2'b10, 16'h0000);
    pulse_rd(); check("t3 dummy", 32'(data_out), 32'h12);
    pulse_rd(); check("t3 nop", 32'(data_out), 32'h00);
    check("t3 jam before rel", 32'(jam_active), 32'd1);
    pulse_rd(); check("t3 jam rel", 32'(jam_active), 32'd0);
    repeat (3) @(negedge clk);
    check("t3 done once", 32'(done_cnt - d0), 32'd1);

    // EXAMINE ABCD preempted by RESET after the C3 byte
    seen_abcd = 1'b0;
    send_cmd(2'b01, 16'hABCD);
    pulse_rd();
    pulse_rd(); check("t4 opc", 32'(data_out), 32'hC3);
    send_cmd(2'b00, 16'h0000);
    check("t4 jam after preempt", 32'(jam_active), 32'd1);
    pulse_rd(); check("t4 dummy", 32'(data_out), 32'hC3);
    pulse_rd(); check("t4 opc2", 32'(data_out), 32'hC3);
    pulse_rd(); check("t4 lo", 32'(data_out), 32'h00);
    pulse_rd(); check("t4 hi", 32'(data_out), 32'h00);
    pulse_rd(); check("t4 jam rel", 32'(jam_active), 32'd0);
    check("t4 no AB/CD byte", 32'(seen_abcd), 32'd0);

    // Reserved op in IDLE, then EXAMINE ignored while busy
    e0 = err_cnt;
    send_cmd(2'b11, 16'h5555);
    @(negedge clk);
    check("t5 err pulse", 32'(err_cnt - e0), 32'd1);
    check("t5 jam idle", 32'(jam_active), 32'd0);
    check("t5 ready", 32'(cmd_ready), 32'd1);
    send_cmd(2'b00, 16'h0000);
    send_cmd(2'b01, 16'h5555);
    pulse_rd();
    pulse_rd(); check("t5 opc", 32'(data_out), 32'hC3);
    pulse_rd(); check("t5 lo", 32'(data_out), 32'h00);
    pulse_rd(); check("t5 hi", 32'(data_out), 32'h00);
    pulse_rd(); check("t5 jam rel", 32'(jam_active), 32'd0);

    // reset_n during OPND, then a normal RESET sequence
    send_cmd(2'b01, 16'h1234);
    pulse_rd();
    pulse_rd(); check("t6 opc", 32'(data_out), 32'hC3);
    @(negedge clk); #2 reset_n = 1'b0;
    #1;
    check("t6 async jam", 32'(jam_active), 32'd0);
    check("t6 async data", 32'(data_out), 32'h00);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    send_cmd(2'b00, 16'h0000);
    pulse_rd();
    pulse_rd(); check("t6 opc again", 32'(data_out), 32'hC3);
    pulse_rd();
    pulse_rd();
    pulse_rd(); check("t6 jam rel", 32'(jam_active), 32'd0);

    // SYNC_STAGES=2, SKIP_RD=0: first byte exactly 3 clk after rd rises
    @(negedge clk); cmd_valid2 = 1'b1;
    @(negedge clk); cmd_valid2 = 1'b0;
    check("t7 jam accept", 32'(jam_active2), 32'd1);
    @(negedge clk); rd2 = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("t7 not yet", 32'(data_out2), 32'h00);
    @(posedge clk); #1;
    check("t7 third clk", 32'(data_out2), 32'hC3);
    @(negedge clk); rd2 = 1'b0;
    repeat (2) @(negedge clk);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
